// File: rtl/weight_loader.sv
// weight_loader
//   Streams weight bytes from a byte-wide valid/ready source, packs them
//   little-endian into DATA_WIDTH-bit words and writes each word into the
//   weight RAM at base_addr + word index (wrapping modulo 2^ADDR_WIDTH).
//
//   Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN
//     When defined, an 8-bit additive checksum over all data bytes is checked
//     against one trailer byte after the last word; a nonzero total sets error.
//     When undefined, no trailer is expected and error is tied low.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start             one-cycle load request (honoured in IDLE only)
//   base_addr         first RAM address, sampled with start
//   word_count        words to load (0..2^ADDR_WIDTH), sampled with start
//   in_valid/in_ready byte handshake; in_byte is the data byte
//   wr_en/wr_addr/wr_data  RAM write port
//   busy              high while receiving, writing or checking
//   done              one-cycle completion pulse
//   error             checksum mismatch, sticky until the next start
module weight_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_in_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic [ADDR_WIDTH:0]   r_word_idx;
  logic [BIDX_W-1:0]     r_byte_idx;
  logic [DATA_WIDTH-1:0] r_partial;

  logic                  w_accept;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_accept    = in_valid && r_in_ready;
  assign w_last_byte = (r_byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
  assign w_last_word = (r_word_idx == (r_word_count - (ADDR_WIDTH + 1)'(1)));

  // Partial word with the incoming byte merged in at the current byte slot.
  always_comb begin
    w_word = r_partial;
    for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
      if (r_byte_idx == BIDX_W'(b)) begin
        w_word[b*8 +: 8] = in_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (word_count == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (w_accept && w_last_byte) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last_word) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          w_next_state = S_CSUM;
`else
          w_next_state = S_DONE;
`endif
        end else begin
          w_next_state = S_RECV;
        end
      end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_next_state = S_DONE;
        end
      end
`endif
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_base       <= '0;
      r_word_count <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_partial    <= '0;
    end else begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      r_in_ready <= (w_next_state == S_RECV) || (w_next_state == S_CSUM);
      r_busy     <= (w_next_state == S_RECV) || (w_next_state == S_WRITE) ||
                    (w_next_state == S_CSUM);
`else
      r_in_ready <= (w_next_state == S_RECV);
      r_busy     <= (w_next_state == S_RECV) || (w_next_state == S_WRITE);
`endif
      r_wr_en <= (w_next_state == S_WRITE);
      r_done  <= (w_next_state == S_DONE);

      if (r_state == S_IDLE && start) begin
        r_base       <= base_addr;
        r_word_count <= word_count;
        r_word_idx   <= '0;
        r_byte_idx   <= '0;
      end

      if (r_state == S_RECV && w_accept) begin
        r_partial  <= w_word;
        r_byte_idx <= w_last_byte ? '0 : r_byte_idx + BIDX_W'(1);
        if (w_last_byte) begin
          r_wr_data <= w_word;
          r_wr_addr <= r_base + r_word_idx[ADDR_WIDTH-1:0];
        end
      end

      if (r_state == S_WRITE && !w_last_word) begin
        r_word_idx <= r_word_idx + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_csum  <= '0;
        r_error <= 1'b0;
      end
      if (r_state == S_RECV && w_accept) begin
        r_csum <= r_csum + in_byte;
      end
      if (r_state == S_CSUM && w_accept) begin
        r_error <= ((r_csum + in_byte) != 8'h00);
      end
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_weight_loader.sv
// Directed testbench for weight_loader: reset state, back-to-back and gapped
// streams, address wrap, reset abort, zero-length load and (with
// WEIGHT_LOADER_CHECKSUM_EN) trailer checking.
module tb_weight_loader;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t wq[$];

  logic [7:0] s1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] s2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] s3 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  weight_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{cyc, wr_addr, wr_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, output int sc);
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    sc         = cyc;
    tick();
    start      = 1'b0;
    if (n != 0) chk("in_ready_after_start", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    logic rdy;
    int   c;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_byte  = b;
    acc      = -1;
    for (int i = 0; i < 50; i++) begin
      rdy = in_ready;
      c   = cyc;
      tick();
      if (rdy === 1'b1) begin
        acc = c;
        break;
      end
    end
    if (acc < 0) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      tick();
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int wc);
    if (idx < wq.size()) begin
      chk({tag, "_addr"}, wq[idx].addr, a);
      chk({tag, "_data"}, wq[idx].data, d);
      if (wc >= 0) chk({tag, "_cycle"}, wq[idx].cyc, wc);
    end else begin
      chk({tag, "_missing"}, 0, 1);
    end
  endtask

  int         sc, dc, a, n0, last_acc, trl_acc;
  int         acc4 [2];
  logic [7:0] sum;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b1;
    in_byte    = 8'hA5;
    base_addr  = '0;
    word_count = '0;
    trl_acc    = -1;

    // Reset with in_valid asserted
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_no_writes", wq.size(), 0);

    // Two words, back-to-back bytes
    n0 = wq.size();
    do_start(10'h000, 11'd2, sc);
    chk("busy_recv", busy, 1);
    for (int i = 0; i < 8; i++) send_byte(s1[i], 0, a);
    in_valid = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    send_byte(8'hB4, 0, trl_acc);
    in_valid = 1'b0;
`endif
    wait_done(dc);
    chk("t1_write_count", wq.size() - n0, 2);
    chk_wr("t1_w0", n0, 10'h000, 32'h12345678, sc + 5);
    chk_wr("t1_w1", n0 + 1, 10'h001, 32'hDEADBEEF, sc + 10);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("t1_done_cycle", dc, trl_acc + 1);
`else
    chk("t1_done_cycle", dc, sc + 11);
`endif
    chk("t1_done_busy", busy, 0);
    chk("t1_error", error, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_hold_addr", wr_addr, 10'h001);
    chk("t1_hold_data", wr_data, 32'hDEADBEEF);

    // Same stream with 3 idle cycles between bytes; a stray start mid-load
    n0 = wq.size();
    do_start(10'h000, 11'd2, sc);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start      = 1'b1;
        base_addr  = 10'h155;
        word_count = 11'd3;
      end
      send_byte(s1[i], (i == 0) ? 0 : 3, a);
      start = 1'b0;
      if (i == 3) acc4[0] = a;
      if (i == 7) acc4[1] = a;
    end
    in_valid = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    send_byte(8'hB4, 0, trl_acc);
    in_valid = 1'b0;
`endif
    wait_done(dc);
    chk("t2_write_count", wq.size() - n0, 2);
    chk_wr("t2_w0", n0, 10'h000, 32'h12345678, acc4[0] + 1);
    chk_wr("t2_w1", n0 + 1, 10'h001, 32'hDEADBEEF, acc4[1] + 1);
    tick();

    // Address wrap from 0x3FF
    n0  = wq.size();
    sum = 8'h00;
    do_start(10'h3FF, 11'd2, sc);
    for (int i = 0; i < 8; i++) begin
      send_byte(s2[i], 0, a);
      sum = sum + s2[i];
    end
    in_valid = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    send_byte(8'h00 - sum, 0, trl_acc);
    in_valid = 1'b0;
`endif
    wait_done(dc);
    chk("t3_write_count", wq.size() - n0, 2);
    chk_wr("t3_w0", n0, 10'h3FF, 32'h44332211, -1);
    chk_wr("t3_w1", n0 + 1, 10'h000, 32'h88776655, -1);
    chk("t3_error", error, 0);
    tick();

    // Reset after two bytes, then a fresh one-word load
    n0 = wq.size();
    do_start(10'h005, 11'd1, sc);
    send_byte(s1[0], 0, a);
    send_byte(s1[1], 0, a);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_abort_in_ready", in_ready, 0);
    chk("t4_abort_busy", busy, 0);
    tick();
    chk("t4_abort_no_write", wq.size() - n0, 0);
    do_start(10'h020, 11'd1, sc);
    for (int i = 0; i < 4; i++) send_byte(s3[i], 0, last_acc);
    in_valid = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    send_byte(8'hF6, 0, trl_acc);
    in_valid = 1'b0;
`endif
    wait_done(dc);
    chk("t4_write_count", wq.size() - n0, 1);
    chk_wr("t4_w0", n0, 10'h020, 32'h04030201, last_acc + 1);
    tick();

    // Zero-length load: done with no writes and no trailer
    n0 = wq.size();
    do_start(10'h010, 11'd0, sc);
    wait_done(dc);
    chk("t5_done_latency", ((dc - sc) >= 1) && ((dc - sc) <= 2), 1);
    chk("t5_no_write", wq.size() - n0, 0);
    chk("t5_error", error, 0);
    tick();
    chk("t5_idle_busy", busy, 0);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // Bad trailer sets a sticky error that the next start clears
    do_start(10'h000, 11'd2, sc);
    for (int i = 0; i < 8; i++) send_byte(s1[i], 0, a);
    in_valid = 1'b0;
    send_byte(8'hB5, 0, trl_acc);
    in_valid = 1'b0;
    wait_done(dc);
    chk("t6_done_cycle", dc, trl_acc + 1);
    chk("t6_error_set", error, 1);
    repeat (3) tick();
    chk("t6_error_sticky", error, 1);
    do_start(10'h000, 11'd1, sc);
    chk("t6_error_cleared", error, 0);
    for (int i = 0; i < 4; i++) send_byte(s3[i], 0, a);
    in_valid = 1'b0;
    send_byte(8'hF6, 0, trl_acc);
    in_valid = 1'b0;
    wait_done(dc);
    chk("t6_error_good", error, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
